bmp_stream_reader: RTL

Byte-stream BMP reader for the image-enhancement datapath, the counterpart of the BMP writer. It accepts a raw 24-bpp BMP file one byte per handshake, parses and validates the 54-byte header, skips to the pixel-data offset, and drops row padding. Pixels leave as RGB words in file order, which is bottom row first, with start-of-frame and end-of-line markers.

---
 rtl/bmp_pkg.sv | 37 +++
 rtl/bmp_stream_reader_if.sv | 22 ++
 rtl/bmp_pixel_assembler.sv | 56 +++++
 rtl/bmp_stream_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// Constants and types shared by the BMP stream reader and writer.
// Header field offsets are byte positions within the 54-byte BMP/DIB header.
package bmp_pkg;

  localparam int unsigned BMP_HDR_SIZE   = 54;
  localparam int unsigned BMP_OFF_SIG    = 0;
  localparam int unsigned BMP_OFF_OFFSET = 10;
  localparam int unsigned BMP_OFF_WIDTH  = 18;
  localparam int unsigned BMP_OFF_HEIGHT = 22;
  localparam int unsigned BMP_OFF_BPP    = 28;
  localparam int unsigned BMP_OFF_COMP   = 30;

  localparam logic [7:0]  BMP_SIG_B = 8'h42;
  localparam logic [7:0]  BMP_SIG_M = 8'h4D;
  localparam logic [15:0] BPP_24    = 16'd24;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StDecide,
    StSkip,
    StPixel,
    StPad,
    StDone,
    StError
  } bmp_state_e;

  function automatic logic in_field(logic [5:0] idx, int unsigned base, int unsigned len);
    return (32'(idx) >= base) && (32'(idx) < base + len);
  endfunction

  // Bytes needed to round a row of 3*width bytes up to a 4-byte boundary.
  function automatic logic [1:0] row_pad(logic [1:0] width_lsb);
    return 2'((4 - ((3 * 32'(width_lsb)) % 4)) % 4);
  endfunction

endpackage

// File: rtl/bmp_stream_reader_if.sv
// Byte-in / pixel-out stream bundle of the BMP reader.
// The slave modport is the reader's view, the master modport is the byte source and pixel sink.
interface bmp_stream_reader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;

  modport master (
    output in_data, in_valid, pix_ready,
    input  in_ready, pix_data, pix_valid, pix_sof, pix_eol
  );

  modport slave (
    input  in_data, in_valid, pix_ready,
    output in_ready, pix_data, pix_valid, pix_sof, pix_eol
  );
endinterface

// File: rtl/bmp_pixel_assembler.sv
// Collects B, G, R file bytes into a one-entry {R,G,B} output register with
// valid/ready handshake and start-of-frame / end-of-line tags.
module bmp_pixel_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        sof_tag,
  input  logic        eol_tag,
  output logic        lane_is_r,
  output logic        load_ok,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  input  logic        pix_ready
);

  logic [1:0] lane_q;
  logic [7:0] b_q, g_q;

  assign lane_is_r = (lane_q == 2'd2);
  assign load_ok   = !pix_valid || pix_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q    <= '0;
      b_q       <= '0;
      g_q       <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      if (clear) begin
        lane_q <= '0;
      end else if (byte_en) begin
        unique case (lane_q)
          2'd0:    begin b_q <= byte_data; lane_q <= 2'd1; end
          2'd1:    begin g_q <= byte_data; lane_q <= 2'd2; end
          default: lane_q <= 2'd0;
        endcase
      end
      if (pix_valid && pix_ready) pix_valid <= 1'b0;
      // The parent only presents the R byte when load_ok, so this never overwrites a held pixel.
      if (byte_en && lane_is_r) begin
        pix_data  <= {byte_data, g_q, b_q};
        pix_valid <= 1'b1;
        pix_sof   <= sof_tag;
        pix_eol   <= eol_tag;
      end
    end
  end

endmodule

// File: rtl/bmp_stream_reader.sv
// Parses a 24-bpp BMP byte stream: validates the header, skips to the pixel data,
// drops row padding and emits pixels in file order with sof/eol markers.
module bmp_stream_reader
  import bmp_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 1024,
  parameter int unsigned MAX_HEIGHT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  bmp_stream_reader_if.slave bus,
  output logic [15:0]        img_width,
  output logic [15:0]        img_height,
  output logic               hdr_valid,
  output logic               busy,
  output logic               done,
  output logic               error
);

  bmp_state_e  state_q, state_d;
  logic [5:0]  hdr_cnt_q;
  logic [15:0] sig_q, bpp_q;
  logic [31:0] off_q, width_q, height_q, comp_q, skip_q;
  logic [15:0] col_q, row_q;
  logic [1:0]  pad_q, pad_len;
  logic        hdr_valid_q, error_q, done_q;
  logic        byte_acc, start_ok, hdr_last, hdr_ok, pix_byte, r_done;
  logic        col_last, row_last, lane_is_r, load_ok;

  assign byte_acc = bus.in_valid && bus.in_ready;
  assign start_ok = start && (state_q inside {StIdle, StDone, StError});
  assign hdr_last = (state_q == StHeader) && byte_acc && (hdr_cnt_q == 6'(BMP_HDR_SIZE - 1));
  assign pix_byte = (state_q == StPixel) && byte_acc;
  assign r_done   = pix_byte && lane_is_r;
  assign col_last = (col_q == width_q[15:0] - 16'd1);
  assign row_last = (row_q == height_q[15:0] - 16'd1);
  assign pad_len  = row_pad(width_q[1:0]);

  // All checked fields end at byte 33, so they are complete when byte 53 arrives.
  assign hdr_ok = (sig_q == {BMP_SIG_M, BMP_SIG_B}) && (bpp_q == BPP_24) && (comp_q == '0)
               && (width_q != '0) && (width_q <= MAX_WIDTH)
               && (height_q != '0) && !height_q[31] && (height_q <= MAX_HEIGHT)
               && (off_q >= BMP_HDR_SIZE);

  assign img_width  = width_q[15:0];
  assign img_height = height_q[15:0];
  assign hdr_valid  = hdr_valid_q;
  assign error      = error_q;
  assign done       = done_q;

  bmp_pixel_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .byte_en   (pix_byte),
    .byte_data (bus.in_data),
    .sof_tag   ((row_q == '0) && (col_q == '0)),
    .eol_tag   (col_last),
    .lane_is_r (lane_is_r),
    .load_ok   (load_ok),
    .pix_data  (bus.pix_data),
    .pix_valid (bus.pix_valid),
    .pix_sof   (bus.pix_sof),
    .pix_eol   (bus.pix_eol),
    .pix_ready (bus.pix_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StHeader;
      StHeader: if (hdr_last) state_d = hdr_ok ? StDecide : StError;
      StDecide: state_d = (off_q > BMP_HDR_SIZE) ? StSkip : StPixel;
      StSkip:   if (byte_acc && skip_q == 32'd1) state_d = StPixel;
      StPixel: begin
        if (r_done && col_last) begin
          if (pad_len != '0) state_d = StPad;
          else if (row_last) state_d = StDone;
        end
      end
      StPad:    if (byte_acc && pad_q == 2'd1) state_d = row_last ? StDone : StPixel;
      StDone: begin
        if (start) state_d = StHeader;
        else if (!bus.pix_valid) state_d = StIdle;
      end
      StError:  if (start) state_d = StHeader;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      StHeader, StSkip, StPad: bus.in_ready = 1'b1;
      StPixel:                 bus.in_ready = !lane_is_r || load_ok;
      StIdle, StError:         busy = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_cnt_q   <= '0;
      sig_q       <= '0;
      bpp_q       <= '0;
      off_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      comp_q      <= '0;
      skip_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pad_q       <= '0;
      hdr_valid_q <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == StDone) && (state_d == StIdle);
      if (start_ok) begin
        hdr_cnt_q   <= '0;
        hdr_valid_q <= 1'b0;
        error_q     <= 1'b0;
        col_q       <= '0;
        row_q       <= '0;
      end
      // Little-endian fields shift in from the top so byte 0 ends up in bits [7:0].
      if (state_q == StHeader && byte_acc) begin
        hdr_cnt_q <= hdr_cnt_q + 6'd1;
        if (in_field(hdr_cnt_q, BMP_OFF_SIG, 2))    sig_q    <= {bus.in_data, sig_q[15:8]};
        if (in_field(hdr_cnt_q, BMP_OFF_OFFSET, 4)) off_q    <= {bus.in_data, off_q[31:8]};
        if (in_field(hdr_cnt_q, BMP_OFF_WIDTH, 4))  width_q  <= {bus.in_data, width_q[31:8]};
        if (in_field(hdr_cnt_q, BMP_OFF_HEIGHT, 4)) height_q <= {bus.in_data, height_q[31:8]};
        if (in_field(hdr_cnt_q, BMP_OFF_BPP, 2))    bpp_q    <= {bus.in_data, bpp_q[15:8]};
        if (in_field(hdr_cnt_q, BMP_OFF_COMP, 4))   comp_q   <= {bus.in_data, comp_q[31:8]};
      end
      if (hdr_last) begin
        hdr_valid_q <= hdr_ok;
        error_q     <= !hdr_ok;
        skip_q      <= off_q - BMP_HDR_SIZE;
      end
      if (state_q == StSkip && byte_acc && skip_q != '0) skip_q <= skip_q - 32'd1;
      if (r_done) begin
        if (col_last) begin
          col_q <= '0;
          pad_q <= pad_len;
          if (pad_len == '0) row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
      if (state_q == StPad && byte_acc) begin
        pad_q <= pad_q - 2'd1;
        if (pad_q == 2'd1) row_q <= row_q + 16'd1;
      end
    end
  end

endmodule
